// File: rtl/io_evt_arb_pkg.sv
// Shared types and limits for the io_event_trig_arb event counter / trigger arbiter.
// No logic; pure declarations.
// Imported by io_evt_arb_chan and io_event_trig_arb.
package io_evt_arb_pkg;

  // Upper bound on the number of channels the arbiter is written for.
  localparam int MAX_CH = 16;

  // Per-channel counting state.
  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_COUNT = 2'd1,
    CH_DONE  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/io_evt_arb_chan.sv
// One event-counting channel: FSM, modulo counter, pending and sticky overflow flags.
// Latency: a hitting event sets pending on the same edge it is sampled.
// Backpressure: pending holds until grant_i; a further hit while pending sets overflow.
module io_evt_arb_chan
  import io_evt_arb_pkg::*;
#(
  parameter int COUNTER_WIDTH = 6
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     event_i,
  input  logic                     en_i,
  input  logic                     oneshot_i,
  input  logic [COUNTER_WIDTH-1:0] target_i,
  input  logic                     clr_i,
  input  logic                     grant_i,
  output logic                     pending_o,
  output logic                     overflow_o,
  output logic [COUNTER_WIDTH-1:0] count_o
);

  chan_state_e              state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     pend_q, pend_d;
  logic                     ovf_q, ovf_d;
  logic                     hit;

  // Next-state logic: disable beats clear, clear beats a same-cycle hit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q & ~grant_i;
    ovf_d   = ovf_q;
    // T=0 never matches, so the counter free-runs and wraps.
    hit     = (state_q == CH_COUNT) && event_i && (target_i != '0) &&
              (cnt_q == target_i - COUNTER_WIDTH'(1));

    if (clr_i) ovf_d = 1'b0;

    if (!en_i) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (clr_i) begin
      state_d = CH_COUNT;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        CH_IDLE:  state_d = CH_COUNT;
        CH_COUNT: begin
          if (event_i) begin
            if (hit) begin
              cnt_d  = '0;
              pend_d = 1'b1;
              // A hit landing while the previous one is being granted is not lost.
              if (pend_q && !grant_i) ovf_d = 1'b1;
              if (oneshot_i) state_d = CH_DONE;
            end else begin
              cnt_d = cnt_q + COUNTER_WIDTH'(1);
            end
          end
        end
        CH_DONE:  state_d = CH_DONE;
        default:  state_d = CH_IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;
  assign count_o    = cnt_q;

endmodule

// File: rtl/io_event_trig_arb.sv
// N_CH event counters whose hits are serialised onto one req/ack trigger port.
// Latency: hit at edge k -> pending at k -> trig_req_o at k+1; one trigger per cycle back-to-back.
// Backpressure: trig_req_o/trig_id_o hold until trig_ack_i; one pending per channel, extra hits flag overflow.
// Build option: define IO_EVT_ARB_FIXED_PRIO_EN for lowest-id-wins instead of round-robin.
module io_event_trig_arb
  import io_evt_arb_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int COUNTER_WIDTH = 6,
  parameter int ID_W          = $clog2(N_CH)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [N_CH-1:0]               event_i,
  input  logic [N_CH-1:0]               cfg_en_i,
  input  logic [N_CH-1:0]               cfg_oneshot_i,
  input  logic [N_CH*COUNTER_WIDTH-1:0] cfg_target_i,
  input  logic [N_CH-1:0]               cfg_clr_i,
  output logic                          trig_req_o,
  output logic [ID_W-1:0]               trig_id_o,
  input  logic                          trig_ack_i,
  output logic [N_CH-1:0]               pending_o,
  output logic [N_CH-1:0]               overflow_o,
  output logic [N_CH*COUNTER_WIDTH-1:0] count_o
);

  if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_cfg
    $error("io_event_trig_arb: N_CH out of range");
  end

  logic [N_CH-1:0] pend_vec;
  logic [N_CH-1:0] req_vec;
  logic [N_CH-1:0] grant_vec;
  logic            trig_req_q;
  logic [ID_W-1:0] trig_id_q;
  logic            slot_free;
  logic            pick_vld;
  logic [ID_W-1:0] pick_id;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    io_evt_arb_chan #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_chan (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .event_i    (event_i[c]),
      .en_i       (cfg_en_i[c]),
      .oneshot_i  (cfg_oneshot_i[c]),
      .target_i   (cfg_target_i[c*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .clr_i      (cfg_clr_i[c]),
      .grant_i    (grant_vec[c]),
      .pending_o  (pend_vec[c]),
      .overflow_o (overflow_o[c]),
      .count_o    (count_o[c*COUNTER_WIDTH +: COUNTER_WIDTH])
    );
  end

  // A channel being disabled or cleared this cycle must not be granted.
  assign req_vec   = pend_vec & cfg_en_i & ~cfg_clr_i;
  assign slot_free = ~trig_req_q | trig_ack_i;

`ifdef IO_EVT_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest requesting id wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_vec[ID_W'(i)]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q;

  // Round-robin: search starts just after the last granted id.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(rr_ptr_q) + 1 + i) % N_CH;
      if (!pick_vld && req_vec[ID_W'(idx)]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  // Remember the last granted channel; reset points at N_CH-1 so channel 0 leads.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q <= ID_W'(N_CH - 1);
    end else if (slot_free && pick_vld) begin
      rr_ptr_q <= pick_id;
    end
  end
`endif

  // Grant pulse to the chosen channel, only when the slot can take it.
  always_comb begin
    grant_vec = '0;
    if (slot_free && pick_vld) grant_vec[pick_id] = 1'b1;
  end

  // Output slot: load on a free slot, otherwise hold until acknowledged.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      trig_req_q <= 1'b0;
      trig_id_q  <= '0;
    end else if (slot_free) begin
      if (pick_vld) begin
        trig_req_q <= 1'b1;
        trig_id_q  <= pick_id;
      end else begin
        trig_req_q <= 1'b0;
      end
    end
  end

  assign trig_req_o = trig_req_q;
  assign trig_id_o  = trig_id_q;
  assign pending_o  = pend_vec;

endmodule

// File: tb/tb_io_event_trig_arb.sv
// Directed bench for io_event_trig_arb with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// Honours IO_EVT_ARB_FIXED_PRIO_EN for the arbitration-order expectations.
module tb_io_event_trig_arb;

  localparam int N  = 4;
  localparam int W  = 6;
  localparam int IW = 2;

  logic          clk_i;
  logic          rstn_i;
  logic [N-1:0]  event_i;
  logic [N-1:0]  cfg_en_i;
  logic [N-1:0]  cfg_oneshot_i;
  logic [N*W-1:0] cfg_target_i;
  logic [N-1:0]  cfg_clr_i;
  logic          trig_req_o;
  logic [IW-1:0] trig_id_o;
  logic          trig_ack_i;
  logic [N-1:0]  pending_o;
  logic [N-1:0]  overflow_o;
  logic [N*W-1:0] count_o;

  int n_tests;
  int n_fail;

  io_event_trig_arb #(.N_CH(N), .COUNTER_WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .event_i       (event_i),
    .cfg_en_i      (cfg_en_i),
    .cfg_oneshot_i (cfg_oneshot_i),
    .cfg_target_i  (cfg_target_i),
    .cfg_clr_i     (cfg_clr_i),
    .trig_req_o    (trig_req_o),
    .trig_id_o     (trig_id_o),
    .trig_ack_i    (trig_ack_i),
    .pending_o     (pending_o),
    .overflow_o    (overflow_o),
    .count_o       (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    event_i       = '0;
    cfg_en_i      = '0;
    cfg_oneshot_i = '0;
    cfg_target_i  = '0;
    cfg_clr_i     = '0;
    trig_ack_i    = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstn_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn_i = 1'b0;
    #3;
    n_tests++;
    if (trig_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", trig_req_o); end
    n_tests++;
    if (trig_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", trig_id_o); end
    n_tests++;
    if (pending_o !== 4'h0) begin n_fail++; $display("FAIL reset_pending: got %0h expected 0", pending_o); end
    n_tests++;
    if (overflow_o !== 4'h0) begin n_fail++; $display("FAIL reset_overflow: got %0h expected 0", overflow_o); end
    n_tests++;
    if (count_o !== 24'h0) begin n_fail++; $display("FAIL reset_count: got %0h expected 0", count_o); end
    tick();
    rstn_i = 1'b1;
  endtask

  task automatic test_continuous();
    int trig_cnt;
    trig_cnt = 0;
    cfg_target_i[5:0] = 6'd3;
    cfg_en_i[0] = 1'b1;
    trig_ack_i  = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      event_i[0] = 1'b1;
      tick();
      if (trig_req_o === 1'b1) begin
        trig_cnt++;
        n_tests++;
        if (trig_id_o !== 2'd0) begin n_fail++; $display("FAIL cont_id: got %0d expected 0", trig_id_o); end
      end
      if (i == 2 || i == 5) begin
        n_tests++;
        if (pending_o[0] !== 1'b1) begin n_fail++; $display("FAIL cont_pending ev%0d: got %0b expected 1", i + 1, pending_o[0]); end
      end
    end
    event_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (trig_req_o === 1'b1) trig_cnt++;
    end
    n_tests++;
    if (trig_cnt !== 2) begin n_fail++; $display("FAIL cont_trig_count: got %0d expected 2", trig_cnt); end
    n_tests++;
    if (count_o[5:0] !== 6'd1) begin n_fail++; $display("FAIL cont_count: got %0d expected 1", count_o[5:0]); end
    cfg_en_i[0] = 1'b0;
    tick();
    n_tests++;
    if (count_o[5:0] !== 6'd0) begin n_fail++; $display("FAIL cont_disable_count: got %0d expected 0", count_o[5:0]); end
    trig_ack_i = 1'b0;
  endtask

  task automatic test_oneshot();
    int trig_cnt;
    trig_cnt = 0;
    cfg_target_i[11:6] = 6'd2;
    cfg_oneshot_i[1]   = 1'b1;
    cfg_en_i[1]        = 1'b1;
    trig_ack_i         = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      event_i[1] = (i < 5);
      tick();
      if (trig_req_o === 1'b1) begin
        trig_cnt++;
        n_tests++;
        if (trig_id_o !== 2'd1) begin n_fail++; $display("FAIL oneshot_id: got %0d expected 1", trig_id_o); end
      end
    end
    n_tests++;
    if (trig_cnt !== 1) begin n_fail++; $display("FAIL oneshot_trig_count: got %0d expected 1", trig_cnt); end
    n_tests++;
    if (count_o[11:6] !== 6'd0) begin n_fail++; $display("FAIL oneshot_done_count: got %0d expected 0", count_o[11:6]); end
    cfg_clr_i[1] = 1'b1;
    tick();
    cfg_clr_i[1] = 1'b0;
    event_i[1]   = 1'b1;
    tick();
    n_tests++;
    if ({pending_o[1], count_o[11:6]} !== {1'b0, 6'd1}) begin n_fail++; $display("FAIL oneshot_resume_ev1: got pend=%0b cnt=%0d expected pend=0 cnt=1", pending_o[1], count_o[11:6]); end
    tick();
    n_tests++;
    if ({pending_o[1], count_o[11:6]} !== {1'b1, 6'd0}) begin n_fail++; $display("FAIL oneshot_resume_hit: got pend=%0b cnt=%0d expected pend=1 cnt=0", pending_o[1], count_o[11:6]); end
    event_i[1] = 1'b0;
    tick();
    n_tests++;
    if ({trig_req_o, trig_id_o} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL oneshot_resume_trig: got req=%0b id=%0d expected req=1 id=1", trig_req_o, trig_id_o); end
    tick();
    n_tests++;
    if (trig_req_o !== 1'b0) begin n_fail++; $display("FAIL oneshot_req_drop: got %0b expected 0", trig_req_o); end
    cfg_en_i[1]      = 1'b0;
    cfg_oneshot_i[1] = 1'b0;
    trig_ack_i       = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_a [4];
    int exp_b [2];
`ifdef IO_EVT_ARB_FIXED_PRIO_EN
    exp_a = '{0, 1, 2, 3};
    exp_b = '{0, 1};
`else
    exp_a = '{1, 2, 3, 0};
    exp_b = '{1, 0};
`endif
    apply_reset();
    cfg_target_i = {6'd1, 6'd1, 6'd1, 6'd1};
    cfg_en_i     = 4'hF;
    tick();
    event_i = 4'hF;
    tick();
    n_tests++;
    if ({trig_req_o, pending_o} !== {1'b0, 4'hF}) begin n_fail++; $display("FAIL b2b_all_pending: got req=%0b pend=%0h expected req=0 pend=f", trig_req_o, pending_o); end
    // ch0 hits again while its first trigger enters the slot
    event_i = 4'h1;
    tick();
    n_tests++;
    if ({trig_req_o, trig_id_o, pending_o, overflow_o} !== {1'b1, 2'd0, 4'hF, 4'h0}) begin
      n_fail++;
      $display("FAIL b2b_first_grant: got req=%0b id=%0d pend=%0h ovf=%0h expected req=1 id=0 pend=f ovf=0", trig_req_o, trig_id_o, pending_o, overflow_o);
    end
    event_i = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({trig_req_o, trig_id_o} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL b2b_hold cyc%0d: got req=%0b id=%0d expected req=1 id=0", i, trig_req_o, trig_id_o); end
    end
    trig_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if ({trig_req_o, trig_id_o} !== {1'b1, IW'(exp_a[k])}) begin n_fail++; $display("FAIL b2b_seq%0d: got req=%0b id=%0d expected req=1 id=%0d", k, trig_req_o, trig_id_o, exp_a[k]); end
    end
    tick();
    n_tests++;
    if ({trig_req_o, pending_o} !== {1'b0, 4'h0}) begin n_fail++; $display("FAIL b2b_drain: got req=%0b pend=%0h expected req=0 pend=0", trig_req_o, pending_o); end
    event_i = 4'h3;
    tick();
    event_i = 4'h0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if ({trig_req_o, trig_id_o} !== {1'b1, IW'(exp_b[k])}) begin n_fail++; $display("FAIL b2b_round2_%0d: got req=%0b id=%0d expected req=1 id=%0d", k, trig_req_o, trig_id_o, exp_b[k]); end
    end
    tick();
    n_tests++;
    if (trig_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_round2_drop: got %0b expected 0", trig_req_o); end
    trig_ack_i = 1'b0;
    cfg_en_i   = 4'h0;
    tick();
  endtask

  task automatic test_overflow();
    cfg_target_i[17:12] = 6'd1;
    cfg_en_i[2]         = 1'b1;
    trig_ack_i          = 1'b0;
    tick();
    event_i[2] = 1'b1;
    tick();
    n_tests++;
    if ({pending_o[2], overflow_o[2]} !== 2'b10) begin n_fail++; $display("FAIL ovf_first_hit: got pend=%0b ovf=%0b expected pend=1 ovf=0", pending_o[2], overflow_o[2]); end
    tick();
    n_tests++;
    if ({trig_req_o, trig_id_o, pending_o[2], overflow_o[2]} !== {1'b1, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_second_hit: got req=%0b id=%0d pend=%0b ovf=%0b expected req=1 id=2 pend=1 ovf=0", trig_req_o, trig_id_o, pending_o[2], overflow_o[2]);
    end
    tick();
    n_tests++;
    if (overflow_o[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_third_hit: got %0b expected 1", overflow_o[2]); end
    event_i[2]  = 1'b0;
    cfg_en_i[2] = 1'b0;
    tick();
    n_tests++;
    if ({pending_o[2], overflow_o[2], count_o[17:12], trig_req_o, trig_id_o} !== {1'b0, 1'b1, 6'd0, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL ovf_disable: got pend=%0b ovf=%0b cnt=%0d req=%0b id=%0d expected pend=0 ovf=1 cnt=0 req=1 id=2", pending_o[2], overflow_o[2], count_o[17:12], trig_req_o, trig_id_o);
    end
    cfg_en_i[2]  = 1'b1;
    cfg_clr_i[2] = 1'b1;
    tick();
    n_tests++;
    if ({pending_o[2], overflow_o[2]} !== 2'b00) begin n_fail++; $display("FAIL ovf_clear: got pend=%0b ovf=%0b expected 0 0", pending_o[2], overflow_o[2]); end
    cfg_clr_i[2] = 1'b0;
    trig_ack_i   = 1'b1;
    tick();
    n_tests++;
    if (trig_req_o !== 1'b0) begin n_fail++; $display("FAIL ovf_slot_complete: got %0b expected 0", trig_req_o); end
    trig_ack_i  = 1'b0;
    cfg_en_i[2] = 1'b0;
    tick();
  endtask

  task automatic test_free_run();
    int trig_cnt;
    trig_cnt = 0;
    cfg_target_i[23:18] = 6'd0;
    cfg_en_i[3]         = 1'b1;
    event_i[3]          = 1'b1;
    trig_ack_i          = 1'b1;
    tick();
    n_tests++;
    if (count_o[23:18] !== 6'd0) begin n_fail++; $display("FAIL free_idle_no_count: got %0d expected 0", count_o[23:18]); end
    for (int i = 0; i < 70; i++) begin
      tick();
      if (trig_req_o === 1'b1) trig_cnt++;
    end
    n_tests++;
    if (trig_cnt !== 0) begin n_fail++; $display("FAIL free_no_trigger: got %0d expected 0", trig_cnt); end
    n_tests++;
    if (count_o[23:18] !== 6'd6) begin n_fail++; $display("FAIL free_wrap_count: got %0d expected 6", count_o[23:18]); end
    event_i[3]  = 1'b0;
    cfg_en_i[3] = 1'b0;
    trig_ack_i  = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    cfg_target_i[11:6] = 6'd1;
    cfg_en_i[1]        = 1'b1;
    trig_ack_i         = 1'b0;
    tick();
    event_i[1] = 1'b1;
    tick();
    tick();
    tick();
    n_tests++;
    if ({trig_req_o, trig_id_o, pending_o[1], overflow_o[1]} !== {1'b1, 2'd1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_pre: got req=%0b id=%0d pend=%0b ovf=%0b expected 1 1 1 1", trig_req_o, trig_id_o, pending_o[1], overflow_o[1]);
    end
    #2;
    rstn_i = 1'b0;
    clear_inputs();
    #1;
    n_tests++;
    if ({trig_req_o, trig_id_o, pending_o, overflow_o, count_o} !== {1'b0, 2'd0, 4'h0, 4'h0, 24'h0}) begin
      n_fail++;
      $display("FAIL areset_outputs: got req=%0b id=%0d pend=%0h ovf=%0h cnt=%0h expected all 0", trig_req_o, trig_id_o, pending_o, overflow_o, count_o);
    end
    tick();
    rstn_i = 1'b1;
    cfg_target_i = {6'd0, 6'd1, 6'd0, 6'd1};
    cfg_en_i     = 4'b0101;
    tick();
    event_i = 4'b0101;
    tick();
    event_i = 4'b0000;
    tick();
    n_tests++;
    if ({trig_req_o, trig_id_o} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL areset_first_grant: got req=%0b id=%0d expected req=1 id=0", trig_req_o, trig_id_o); end
    trig_ack_i = 1'b1;
    tick();
    n_tests++;
    if ({trig_req_o, trig_id_o} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL areset_second_grant: got req=%0b id=%0d expected req=1 id=2", trig_req_o, trig_id_o); end
    tick();
    n_tests++;
    if (trig_req_o !== 1'b0) begin n_fail++; $display("FAIL areset_drain: got %0b expected 0", trig_req_o); end
    clear_inputs();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_continuous();
    test_oneshot();
    test_back_to_back();
    test_overflow();
    test_free_run();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
